// File: rtl/cpu_defs.sv
// Shared definitions for the fetch unit: opcode/funct encodings, FSM state
// encoding, next-PC source selection and small decode helpers.
package cpu_defs;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_HOLD  = 2'b01,
    ST_HALT  = 2'b10
  } fetch_state_e;

  typedef enum logic [1:0] {
    SEL_SEQ  = 2'b00,
    SEL_JUMP = 2'b01,
    SEL_JR   = 2'b10
  } npc_sel_e;

  // Pick the next-PC source. JR beats everything, J/JAL use the jump index,
  // and every other opcode (known or not) falls through to the sequential
  // path, where a taken branch shows up as a non-zero branch_offset.
  function automatic npc_sel_e decode_npc_sel(input logic [5:0] opcode,
                                              input logic [5:0] funct);
    npc_sel_e sel;
    sel = SEL_SEQ;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FUNCT_JR) begin
          sel = SEL_JR;
        end else begin
          sel = SEL_SEQ;
        end
      end
      OP_J, OP_JAL: sel = SEL_JUMP;
      OP_BEQ, OP_BNE, OP_ADDI, OP_XORI, OP_LW, OP_SW: sel = SEL_SEQ;
      default: sel = SEL_SEQ;
    endcase
    return sel;
  endfunction

  // A fetch address is word aligned only when its two low bits are zero.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection. Arithmetic is plain 32-bit, so carries
// out of bit 31 wrap around.
module next_pc_calc
  import cpu_defs::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] branch_offset,
  input  logic [31:0] pc_plus4,
  output logic [31:0] next_pc,
  output logic        misaligned
);

  npc_sel_e sel_s;

  // Select the next PC from register target, jump index or sequential+offset.
  always_comb begin
    sel_s   = decode_npc_sel(opcode, funct);
    next_pc = pc_plus4 + branch_offset;
    case (sel_s)
      SEL_JR:   next_pc = jr_target;
      SEL_JUMP: next_pc = {pc_plus4[31:28], jump_index, 2'b00};
      SEL_SEQ:  next_pc = pc_plus4 + branch_offset;
      default:  next_pc = pc_plus4 + branch_offset;
    endcase
    misaligned = is_misaligned(next_pc[1:0]);
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time,
// hands it to the core and advances the PC when the core is done with it.
// A misaligned next PC latches a sticky error and parks the unit in HALT.
module pc_fetch_unit
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  input  logic [31:0] branch_offset,
  input  logic        advance,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        misalign_err
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4_q, pc_plus4_d;
  logic [31:0] instr_q, instr_d;
  logic        instr_valid_q, instr_valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0] next_pc_s;
  logic        next_misaligned_s;
  logic        fetch_req_s;

  next_pc_calc u_next_pc_calc (
    .opcode        (opcode),
    .funct         (funct),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .branch_offset (branch_offset),
    .pc_plus4      (pc_plus4_q),
    .next_pc       (next_pc_s),
    .misaligned    (next_misaligned_s)
  );

  // State register; reset parks the FSM in FETCH so fetching starts right after release.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: ack moves FETCH to HOLD, advance moves HOLD on, HALT is terminal.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          if (next_misaligned_s) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_HALT;
    endcase
  end

  // Output decode: only FETCH requests memory.
  always_comb begin
    fetch_req_s = 1'b0;
    case (state_q)
      ST_FETCH: fetch_req_s = 1'b1;
      ST_HOLD:  fetch_req_s = 1'b0;
      ST_HALT:  fetch_req_s = 1'b0;
      default:  fetch_req_s = 1'b0;
    endcase
  end

  // Datapath next values: capture the fetched word, step the PC, latch misalignment.
  always_comb begin
    pc_d          = pc_q;
    pc_plus4_d    = pc_plus4_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    misalign_d    = misalign_q;
    case (state_q)
      ST_FETCH: begin
        if (imem_ack) begin
          instr_d       = imem_data;
          instr_valid_d = 1'b1;
        end else begin
          instr_valid_d = 1'b0;
        end
      end
      ST_HOLD: begin
        if (advance) begin
          instr_valid_d = 1'b0;
          if (next_misaligned_s) begin
            misalign_d = 1'b1;
          end else begin
            pc_d       = next_pc_s;
            pc_plus4_d = next_pc_s + 32'd4;
          end
        end else begin
          instr_valid_d = 1'b1;
        end
      end
      ST_HALT: instr_valid_d = 1'b0;
      default: instr_valid_d = 1'b0;
    endcase
  end

  // Datapath registers; an ack coincident with reset is dropped here.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_plus4_q    <= RESET_PC + 32'd4;
      instr_q       <= 32'h0000_0000;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      pc_plus4_q    <= pc_plus4_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
    end
  end

  // Handshake outputs are forced low for the whole time reset is high,
  // including the first cycle before the reset edge has been seen.
  assign imem_req     = fetch_req_s & ~reset;
  assign instr_valid  = instr_valid_q & ~reset;
  assign imem_addr    = pc_q;
  assign pc           = pc_q;
  assign pc_plus4     = pc_plus4_q;
  assign instr        = instr_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit with hand-computed expected values.
module tb_pc_fetch_unit;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] branch_offset;
  logic        advance;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_data;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        misalign_err;

  int n_checks;
  int n_fail;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct         (funct),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .branch_offset (branch_offset),
    .advance       (advance),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_data     (imem_data),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock, then sample 1ns after the edge; inputs change right after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    imem_ack  = 1'b1;
    imem_data = data;
    step();
    imem_ack  = 1'b0;
  endtask

  task automatic do_advance(input logic [5:0] op, input logic [5:0] fn, input logic [25:0] idx,
                            input logic [31:0] jr, input logic [31:0] off);
    opcode        = op;
    funct         = fn;
    jump_index    = idx;
    jr_target     = jr;
    branch_offset = off;
    advance       = 1'b1;
    step();
    advance       = 1'b0;
    branch_offset = 32'h0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    reset         = 1'b1;
    opcode        = 6'b000000;
    funct         = 6'b000000;
    jump_index    = 26'h0;
    jr_target     = 32'h0;
    branch_offset = 32'h0;
    advance       = 1'b0;
    imem_ack      = 1'b0;
    imem_data     = 32'h0;

    step();
    step();
    check("rst_req",      {31'h0, imem_req}, 32'h0);
    check("rst_valid",    {31'h0, instr_valid}, 32'h0);
    check("rst_err",      {31'h0, misalign_err}, 32'h0);
    check("rst_instr",    instr, 32'h0);
    check("rst_pc",       pc, 32'h0);
    check("rst_pc_plus4", pc_plus4, 32'h4);

    // Release reset, three wait cycles, then ack.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_req",   {31'h0, imem_req}, 32'h1);
      check("wait_addr",  imem_addr, 32'h0);
      check("wait_valid", {31'h0, instr_valid}, 32'h0);
    end
    fetch(32'h2008_0005);
    check("ack_valid", {31'h0, instr_valid}, 32'h1);
    check("ack_instr", instr, 32'h2008_0005);
    check("ack_req",   {31'h0, imem_req}, 32'h0);

    // ADDI sequential advance.
    do_advance(6'b001000, 6'b000000, 26'h0, 32'h0, 32'h0);
    check("addi_pc",    pc, 32'h4);
    check("addi_pc4",   pc_plus4, 32'h8);
    check("addi_valid", {31'h0, instr_valid}, 32'h0);
    check("addi_req",   {31'h0, imem_req}, 32'h1);

    // Advance while fetching must be ignored.
    do_advance(6'b000010, 6'b000000, 26'h3FF_FFFF, 32'h0, 32'h0);
    check("fetch_adv_pc",  pc, 32'h4);
    check("fetch_adv_req", {31'h0, imem_req}, 32'h1);

    fetch(32'h0);
    do_advance(6'b001000, 6'b000000, 26'h0, 32'h0, 32'h0);
    fetch(32'h0);
    do_advance(6'b001000, 6'b000000, 26'h0, 32'h0, 32'h0);
    fetch(32'h1043_0008);
    // Ack while holding must not overwrite the held word.
    imem_ack  = 1'b1;
    imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack  = 1'b0;
    check("hold_ack_instr", instr, 32'h1043_0008);
    check("hold_ack_valid", {31'h0, instr_valid}, 32'h1);
    do_advance(6'b001000, 6'b000000, 26'h0, 32'h0, 32'h0);
    check("seq_pc_10", pc, 32'h10);

    // BEQ taken: 0x14 + 0x20.
    fetch(32'h0);
    do_advance(6'b000100, 6'b000000, 26'h0, 32'h0, 32'h20);
    check("beq_pc", pc, 32'h34);

    fetch(32'h0);
    do_advance(6'b000000, 6'b001000, 26'h0, 32'hF000_0010, 32'h0);
    check("jr_hi_pc", pc, 32'hF000_0010);

    // J: {0xF, 0x40 << 2}.
    fetch(32'h0);
    do_advance(6'b000010, 6'b000000, 26'h000_0040, 32'h0, 32'h0);
    check("j_pc", pc, 32'hF000_0100);

    // JR beats a non-zero branch offset.
    fetch(32'h0);
    do_advance(6'b000000, 6'b001000, 26'h0, 32'h0000_0200, 32'h40);
    check("jr_pc", pc, 32'h200);

    // Wrap at the top of the address space.
    fetch(32'h0);
    do_advance(6'b000000, 6'b001000, 26'h0, 32'hFFFF_FFFC, 32'h0);
    check("top_pc",  pc, 32'hFFFF_FFFC);
    check("top_pc4", pc_plus4, 32'h0);
    fetch(32'h0);
    do_advance(6'b001000, 6'b000000, 26'h0, 32'h0, 32'h0);
    check("wrap_pc", pc, 32'h0);

    // Unknown opcode takes the sequential path with offset: 0x4 + 0x8.
    fetch(32'h0);
    do_advance(6'b111111, 6'b001000, 26'h3FF_FFFF, 32'h0000_0100, 32'h8);
    check("unk_pc", pc, 32'hC);

    // JAL from 0xC: {0x0, 0x3FFFFFF << 2}.
    fetch(32'h0);
    do_advance(6'b000011, 6'b000000, 26'h3FF_FFFF, 32'h0, 32'h0);
    check("jal_pc",  pc, 32'h0FFF_FFFC);
    check("jal_pc4", pc_plus4, 32'h1000_0000);

    // Misaligned JR target halts the unit.
    fetch(32'h0);
    do_advance(6'b000000, 6'b001000, 26'h0, 32'h0000_0102, 32'h0);
    check("mis_err",   {31'h0, misalign_err}, 32'h1);
    check("mis_pc",    pc, 32'h0FFF_FFFC);
    check("mis_valid", {31'h0, instr_valid}, 32'h0);
    advance   = 1'b1;
    imem_ack  = 1'b1;
    jr_target = 32'h0000_0100;
    for (int i = 0; i < 10; i++) begin
      step();
      check("halt_req", {31'h0, imem_req}, 32'h0);
    end
    advance  = 1'b0;
    imem_ack = 1'b0;
    check("halt_pc",    pc, 32'h0FFF_FFFC);
    check("halt_valid", {31'h0, instr_valid}, 32'h0);
    check("halt_err",   {31'h0, misalign_err}, 32'h1);

    // Reset clears the error and refetches from RESET_PC.
    reset = 1'b1;
    step();
    check("clr_err", {31'h0, misalign_err}, 32'h0);
    check("clr_pc",  pc, 32'h0);
    reset = 1'b0;
    #1;
    check("refetch_req",  {31'h0, imem_req}, 32'h1);
    check("refetch_addr", imem_addr, 32'h0);

    // Reset with coincident ack during FETCH.
    reset     = 1'b1;
    imem_ack  = 1'b1;
    imem_data = 32'h1234_5678;
    #1;
    check("rst_ack_req_now", {31'h0, imem_req}, 32'h0);
    step();
    check("rst_ack_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_ack_req",   {31'h0, imem_req}, 32'h0);
    check("rst_ack_instr", instr, 32'h0);
    imem_ack = 1'b0;
    reset    = 1'b0;
    #1;
    check("restart_req",  {31'h0, imem_req}, 32'h1);
    check("restart_addr", imem_addr, 32'h0);
    fetch(32'h2008_0005);
    check("restart_instr", instr, 32'h2008_0005);
    check("restart_valid", {31'h0, instr_valid}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  opcode of the current instruction (LW/SW/J/JAL/BEQ/BNE/XORI/ADDI/R-type encodings).
REQ-005 funct  input  6  funct field of the current instruction; 6'b001000 with R-type opcode is JR.
REQ-006 jump_index  input  26  instr[25:0] jump target index.
REQ-007 jr_target  input  32  register value for JR.
REQ-008 branch_offset  input  32  byte offset from the branch test stage; zero when branch not taken.
REQ-009 advance  input  1  core has completed the held instruction; next-PC inputs are valid this cycle.
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 imem_addr  output  32  fetch byte address (equals pc).
REQ-012 imem_ack  input  1  memory returns imem_data this cycle.
REQ-013 imem_data  input  32  fetched instruction word.
REQ-014 instr  output  32  registered held instruction.
REQ-015 instr_valid  output  1  instr is valid and awaiting advance.
REQ-016 pc  output  32  address of the held/fetching instruction.
REQ-017 pc_plus4  output  32  pc + 4, used as the JAL link value.
REQ-018 misalign_err  output  1  sticky: a computed next PC had bits[1:0] != 0.

Function
REQ-019 States SHALL be FETCH, HOLD, HALT.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_ack captures imem_data into instr, sets instr_valid, next state HOLD.
REQ-021 HOLD: imem_req=0, instr_valid=1; advance loads pc with next_pc, clears instr_valid, next state FETCH.
REQ-022 next_pc priority: JR (opcode 000000, funct 001000) -> jr_target; J/JAL -> {pc_plus4[31:28], jump_index, 2'b00}; otherwise pc_plus4 + branch_offset.
REQ-023 Unknown opcodes SHALL take the sequential path (pc_plus4 + branch_offset).
REQ-024 All address arithmetic SHALL be 32-bit modulo 2^32; carries discarded (0xFFFFFFFC + 4 = 0).
REQ-025 On advance in HOLD with next_pc[1:0] != 0: misalign_err<=1, pc unchanged, instr_valid<=0, next state HALT.
REQ-026 HALT: imem_req=0, instr_valid=0; SHALL remain until reset; advance and imem_ack ignored.
REQ-027 advance in FETCH and imem_ack outside FETCH SHALL be ignored.
REQ-028 Minimum throughput: one instruction per two cycles (ack in first FETCH cycle, advance in first HOLD cycle).
REQ-029 imem_req SHALL be held until ack; no timeout.

Reset
REQ-030 While reset is high: imem_req=0, instr_valid=0, misalign_err=0, instr=0, pc=RESET_PC, pc_plus4=RESET_PC+4.
REQ-031 Reset SHALL override any state, including mid-fetch and HALT; FETCH is entered the cycle after release.
REQ-032 An imem_ack coincident with reset SHALL be discarded.

Structure
REQ-033 Opcode constants, JR funct code, and state encoding SHALL live in shared package cpu_defs.
REQ-034 Next-PC selection SHALL be a combinational sub-module next_pc_calc; the FSM and registers stay in pc_fetch_unit.

Verification
REQ-035 Reset release, ack after 3 wait cycles with data 0x20080005 -> imem_addr=0x0 throughout, instr_valid rises after ack, instr=0x20080005.
REQ-036 HOLD, opcode ADDI, branch_offset 0, advance -> pc=0x4; BEQ at pc 0x10 with branch_offset 0x20 -> pc=0x34.
REQ-037 J at pc 0xF0000010, jump_index 0x0000040 -> pc=0xF0000100; JR with jr_target 0x00000200 -> pc=0x200 (JR wins over branch_offset 0x40).
REQ-038 JR with jr_target 0x00000102 -> misalign_err=1, pc unchanged, imem_req stays 0 for 10 cycles; reset clears error and refetches RESET_PC.
REQ-039 pc 0xFFFFFFFC sequential advance -> pc=0x00000000; pc_plus4 at 0xFFFFFFFC reads 0x0.
REQ-040 Reset asserted during FETCH with coincident ack -> instr_valid=0 and imem_req=0 during reset; fetch restarts at RESET_PC.
